// File: rtl/vga_line_fetch.sv
// Scanline prefetcher: fills ping-pong line buffers from word-serial memory,
// paced by the VGA syncs, and serves palette-mapped pixels with 2-cycle latency.
module vga_line_fetch #(
  parameter int          H_WORDS = 160,
  parameter int          V_LINES = 480,
  parameter logic [2:0]  TINT    = 3'b111
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic [5:0]  red,
  output logic [5:0]  green,
  output logic [5:0]  blue,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, REQ, NEXT} state_t;

  state_t       state_q, state_d;
  logic [8:0]   line_q, line_d;
  logic [7:0]   word_q, word_d;
  logic         frame2_q, frame2_d;
  logic         vs_pend_q, vs_pend_d;
  logic         overrun_q, overrun_d;
  logic         wr_en;

  logic         hs_q, vs_q;
  logic [8:0]   last_y_q;
  logic         line_seen_q;

  logic         rd_bank_q;
  logic [7:0]   rd_word_q;
  logic [1:0]   rd_sel_q;
  logic [15:0]  rd_data;
  logic [3:0]   pix_idx;
  logic [5:0]   pal;
  logic [5:0]   red_q, green_q, blue_q;

  logic [15:0]  lbuf [2][H_WORDS];

  logic         vs_fall, hs_fall, hs_trig, vs_now;
  logic [9:0]   next_line;

  assign vs_fall   = vs_q & ~vga_vs;
  assign hs_fall   = hs_q & ~vga_hs;
  assign next_line = {1'b0, last_y_q} + 10'd2;
  // A vsync edge always takes priority; a same-cycle hsync edge is ignored.
  assign hs_trig   = hs_fall & vga_vs & line_seen_q & ~vs_fall
                   & (next_line < 10'(V_LINES));
  assign vs_now    = vs_pend_q | vs_fall;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    word_d    = word_q;
    frame2_d  = frame2_q;
    vs_pend_d = vs_pend_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    mem_req   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vs_fall) begin
          line_d = '0; word_d = '0; frame2_d = 1'b1; state_d = REQ;
        end else if (hs_trig) begin
          line_d = next_line[8:0]; word_d = '0; frame2_d = 1'b0; state_d = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (vs_fall) vs_pend_d = 1'b1;
        if (mem_ack) begin
          wr_en = 1'b1;
          if (vs_now) begin
            line_d = '0; word_d = '0; frame2_d = 1'b1; vs_pend_d = 1'b0;
          end else if (word_q == 8'(H_WORDS - 1)) begin
            state_d = NEXT;
          end else begin
            word_d = word_q + 8'd1;
          end
        end
      end
      NEXT: begin
        if (vs_now) begin
          line_d = '0; word_d = '0; frame2_d = 1'b1; vs_pend_d = 1'b0; state_d = REQ;
        end else if (frame2_q) begin
          line_d = 9'd1; word_d = '0; frame2_d = 1'b0; state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (hs_trig && state_q != IDLE) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      word_q      <= '0;
      frame2_q    <= 1'b0;
      vs_pend_q   <= 1'b0;
      overrun_q   <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      last_y_q    <= '0;
      line_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      word_q    <= word_d;
      frame2_q  <= frame2_d;
      vs_pend_q <= vs_pend_d;
      overrun_q <= overrun_d;
      hs_q      <= vga_hs;
      vs_q      <= vga_vs;
      if (x != '0 || y != '0) begin
        last_y_q    <= y;
        line_seen_q <= 1'b1;
      end
      if (vs_fall || hs_fall) line_seen_q <= 1'b0;
    end
  end

  // NOTE: line buffers are not reset; their contents are undefined until fetched.
  always_ff @(posedge clk50) begin
    if (wr_en) lbuf[line_q[0]][word_q] <= mem_rdata;
  end

  always_comb begin
    rd_data = '0;
    if (rd_word_q < 8'(H_WORDS)) rd_data = lbuf[rd_bank_q][rd_word_q];
    unique case (rd_sel_q)
      2'd0: pix_idx = rd_data[3:0];
      2'd1: pix_idx = rd_data[7:4];
      2'd2: pix_idx = rd_data[11:8];
      default: pix_idx = rd_data[15:12];
    endcase
    pal = {pix_idx, pix_idx[3:2]};
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      rd_bank_q <= 1'b0;
      rd_word_q <= '0;
      rd_sel_q  <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      rd_bank_q <= y[0];
      rd_word_q <= x[9:2];
      rd_sel_q  <= x[1:0];
      red_q     <= TINT[2] ? pal : 6'd0;
      green_q   <= TINT[1] ? pal : 6'd0;
      blue_q    <= TINT[0] ? pal : 6'd0;
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign mem_addr = 17'(line_q) * 17'(H_WORDS) + 17'(word_q);
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

endmodule
